// File: rtl/ecc_dp_ram_ctrl.sv
// True-dual-port operand RAM with read-first ports, collision arbitration,
// out-of-range protection and a hardware clear sequencer.
module ecc_dp_ram_ctrl #(
    parameter int DATA     = 256,
    parameter int ADDR     = 6,
    parameter int DEPTH    = 48,
    parameter int READ_LAT = 1,
    parameter int A_WINS   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_req,
    output logic            busy,
    input  logic            a_en,
    input  logic            a_w,
    input  logic [ADDR-1:0] a_adbus,
    input  logic [DATA-1:0] a_data_in,
    output logic [DATA-1:0] a_data_out,
    output logic            a_vld,
    input  logic            b_en,
    input  logic            b_w,
    input  logic [ADDR-1:0] b_adbus,
    input  logic [DATA-1:0] b_data_in,
    output logic [DATA-1:0] b_data_out,
    output logic            b_vld,
    output logic            err_oor,
    output logic            err_col
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state, state_nxt;
    logic [ADDR-1:0] cnt, cnt_nxt;
    logic [DATA-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (cnt == ADDR'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == CLEAR);

    // Port strobes are only honoured in IDLE; every honoured strobe yields
    // exactly one x_vld pulse READ_LAT cycles later, there is no back-pressure.
    logic a_acc, b_acc, a_inr, b_inr;
    logic a_we, b_we, col, a_we_eff, b_we_eff;

    assign a_acc = (state == IDLE) && a_en;
    assign b_acc = (state == IDLE) && b_en;
    assign a_inr = {1'b0, a_adbus} < (ADDR + 1)'(DEPTH);
    assign b_inr = {1'b0, b_adbus} < (ADDR + 1)'(DEPTH);
    assign a_we  = a_acc && a_w && a_inr;
    assign b_we  = b_acc && b_w && b_inr;
    assign col   = a_we && b_we && (a_adbus == b_adbus);

    assign a_we_eff = a_we && !(col && (A_WINS == 0));
    assign b_we_eff = b_we && !(col && (A_WINS != 0));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) mem[cnt] <= '0;
            if (a_we_eff) mem[a_adbus] <= a_data_in;
            if (b_we_eff) mem[b_adbus] <= b_data_in;
        end
    end

    // Read-first: the array is sampled before this edge's writes land.
    logic [DATA-1:0] a_rd, b_rd, a_d1, b_d1;
    logic            a_v1, b_v1;

    assign a_rd = a_inr ? mem[a_adbus] : '0;
    assign b_rd = b_inr ? mem[b_adbus] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_d1    <= '0;
            b_d1    <= '0;
            a_v1    <= 1'b0;
            b_v1    <= 1'b0;
            err_oor <= 1'b0;
            err_col <= 1'b0;
        end else begin
            a_v1 <= a_acc;
            b_v1 <= b_acc;
            if (a_acc) a_d1 <= a_rd;
            if (b_acc) b_d1 <= b_rd;
            err_oor <= err_oor | (a_acc && !a_inr) | (b_acc && !b_inr);
            err_col <= err_col | col;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DATA-1:0] a_d2, b_d2;
            logic            a_v2, b_v2;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_d2 <= '0;
                    b_d2 <= '0;
                    a_v2 <= 1'b0;
                    b_v2 <= 1'b0;
                end else begin
                    a_v2 <= a_v1;
                    b_v2 <= b_v1;
                    if (a_v1) a_d2 <= a_d1;
                    if (b_v1) b_d2 <= b_d1;
                end
            end

            assign a_data_out = a_d2;
            assign b_data_out = b_d2;
            assign a_vld      = a_v2;
            assign b_vld      = b_v2;
        end else begin : g_lat1
            assign a_data_out = a_d1;
            assign b_data_out = b_d1;
            assign a_vld      = a_v1;
            assign b_vld      = b_v1;
        end
    endgenerate

endmodule

// File: tb/tb_ecc_dp_ram_ctrl.sv
// Self-checking bench for ecc_dp_ram_ctrl: reference memory model feeding
// per-port expected-read queues, plus scenario tasks for clear/reset/flags.
module tb_ecc_dp_ram_ctrl;

    localparam int DATA     = 256;
    localparam int ADDR     = 6;
    localparam int DEPTH    = 48;
    localparam int READ_LAT = 1;
    localparam int A_WINS   = 1;
    localparam int TIMEOUT  = 200;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr_req = 1'b0;
    logic            busy;
    logic            a_en = 1'b0, a_w = 1'b0;
    logic [ADDR-1:0] a_adbus = '0;
    logic [DATA-1:0] a_data_in = '0;
    logic [DATA-1:0] a_data_out;
    logic            a_vld;
    logic            b_en = 1'b0, b_w = 1'b0;
    logic [ADDR-1:0] b_adbus = '0;
    logic [DATA-1:0] b_data_in = '0;
    logic [DATA-1:0] b_data_out;
    logic            b_vld;
    logic            err_oor, err_col;

    ecc_dp_ram_ctrl #(
        .DATA(DATA), .ADDR(ADDR), .DEPTH(DEPTH), .READ_LAT(READ_LAT), .A_WINS(A_WINS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy),
        .a_en(a_en), .a_w(a_w), .a_adbus(a_adbus), .a_data_in(a_data_in),
        .a_data_out(a_data_out), .a_vld(a_vld),
        .b_en(b_en), .b_w(b_w), .b_adbus(b_adbus), .b_data_in(b_data_in),
        .b_data_out(b_data_out), .b_vld(b_vld),
        .err_oor(err_oor), .err_col(err_col)
    );

    always #5 clk = ~clk;

    logic [DATA-1:0] exp_a_q[$];
    logic [DATA-1:0] exp_b_q[$];
    logic [DATA-1:0] model_mem [DEPTH];
    logic [DATA-1:0] exp_a, exp_b;
    int              n_vec = 0;
    int              n_err = 0;

    // Scoreboard: every vld pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (a_vld) begin
            n_vec++;
            if (exp_a_q.size() == 0) begin
                n_err++;
                $display("FAIL a_vld_unexpected: got a_vld=1 data=%h, required no pulse", a_data_out);
            end else begin
                exp_a = exp_a_q.pop_front();
                if (a_data_out !== exp_a) begin
                    n_err++;
                    $display("FAIL a_read_data: got %h required %h", a_data_out, exp_a);
                end
            end
        end
        if (b_vld) begin
            n_vec++;
            if (exp_b_q.size() == 0) begin
                n_err++;
                $display("FAIL b_vld_unexpected: got b_vld=1 data=%h, required no pulse", b_data_out);
            end else begin
                exp_b = exp_b_q.pop_front();
                if (b_data_out !== exp_b) begin
                    n_err++;
                    $display("FAIL b_read_data: got %h required %h", b_data_out, exp_b);
                end
            end
        end
    end

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // One clock of port traffic; the model is updated as the DUT should be.
    task automatic drive(input logic ae, input logic aw, input logic [ADDR-1:0] aa,
                         input logic [DATA-1:0] ad, input logic be, input logic bw,
                         input logic [ADDR-1:0] ba, input logic [DATA-1:0] bd);
        logic a_in, b_in, a_wr, b_wr;
        a_en = ae; a_w = aw; a_adbus = aa; a_data_in = ad;
        b_en = be; b_w = bw; b_adbus = ba; b_data_in = bd;
        a_in = int'(aa) < DEPTH;
        b_in = int'(ba) < DEPTH;
        if (ae) exp_a_q.push_back(a_in ? model_mem[aa] : '0);
        if (be) exp_b_q.push_back(b_in ? model_mem[ba] : '0);
        a_wr = ae && aw && a_in;
        b_wr = be && bw && b_in;
        if (a_wr && b_wr && aa == ba) begin
            model_mem[aa] = (A_WINS != 0) ? ad : bd;
        end else begin
            if (a_wr) model_mem[aa] = ad;
            if (b_wr) model_mem[ba] = bd;
        end
        @(posedge clk); #1;
        a_en = 1'b0; a_w = 1'b0; b_en = 1'b0; b_w = 1'b0;
    endtask

    task automatic drain();
        repeat (READ_LAT + 2) @(posedge clk);
        #1;
        n_vec++;
        if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d reads outstanding, required 0/0",
                     exp_a_q.size(), exp_b_q.size());
            exp_a_q.delete();
            exp_b_q.delete();
        end
    endtask

    // Counts cycles with busy high; optionally hammers ports and re-pulses clr_req.
    task automatic count_busy(input logic strobes, input logic repulse, output int n);
        n = 0;
        while (busy === 1'b1 && n < TIMEOUT) begin
            if (strobes) begin
                a_en = 1'($urandom_range(0, 1)); a_w = 1'($urandom_range(0, 1));
                a_adbus = ADDR'($urandom_range(0, DEPTH - 1)); a_data_in = {8{$urandom()}};
                b_en = 1'($urandom_range(0, 1)); b_w = 1'($urandom_range(0, 1));
                b_adbus = ADDR'($urandom_range(0, DEPTH - 1)); b_data_in = {8{$urandom()}};
            end
            clr_req = repulse && (n == 10);
            n++;
            @(posedge clk); #1;
            a_en = 1'b0; a_w = 1'b0; b_en = 1'b0; b_w = 1'b0; clr_req = 1'b0;
        end
    endtask

    task automatic check_busy_len(input string name, input int n);
        n_vec++;
        if (n != DEPTH) begin
            n_err++;
            $display("FAIL %s: got busy for %0d cycles, required %0d", name, n, DEPTH);
        end
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, 1'b0, ADDR'(i), '0, 1'b1, 1'b0, ADDR'(DEPTH - 1 - i), '0);
        drain();
    endtask

    task automatic test_reset();
        int n;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({a_vld, b_vld, err_oor, err_col} !== 4'b0 || a_data_out !== '0 || b_data_out !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got vld=%b%b err=%b%b, required all zero",
                     a_vld, b_vld, err_oor, err_col);
        end
        rst_n = 1'b1;
        count_busy(1'b0, 1'b0, n);
        check_busy_len("reset_clear_len", n);
        model_zero();
        read_all_zero();
    endtask

    task automatic test_cross_port();
        logic [DATA-1:0] v;
        v = {16'hDEAD, 232'h0, 8'h01};
        drive(1'b1, 1'b1, 6'd5, v, 1'b0, 1'b0, '0, '0);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 6'd5, '0);
        drive(1'b1, 1'b1, 6'd9, 256'h44, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b1, 6'd9, 256'h33, 1'b1, 1'b0, 6'd9, '0);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 6'd9, '0);
        drain();
    endtask

    task automatic test_collision();
        n_vec++;
        if (err_col !== 1'b0) begin
            n_err++;
            $display("FAIL err_col_pre: got %b required 0", err_col);
        end
        drive(1'b1, 1'b1, 6'd7, 256'h11, 1'b1, 1'b1, 6'd7, 256'h22);
        drive(1'b1, 1'b0, 6'd7, '0, 1'b1, 1'b0, 6'd7, '0);
        drain();
        n_vec++;
        if (err_col !== 1'b1) begin
            n_err++;
            $display("FAIL err_col_set: got %b required 1", err_col);
        end
    endtask

    task automatic test_oor();
        n_vec++;
        if (err_oor !== 1'b0) begin
            n_err++;
            $display("FAIL err_oor_pre: got %b required 0", err_oor);
        end
        drive(1'b1, 1'b1, 6'd50, 256'hBAD, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 6'd63, '0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 6'd2, '0, 1'b1, 1'b0, 6'd18, '0);
        drive(1'b1, 1'b0, 6'd47, '0, 1'b1, 1'b0, 6'd48, '0);
        drain();
        n_vec++;
        if (err_oor !== 1'b1) begin
            n_err++;
            $display("FAIL err_oor_set: got %b required 1", err_oor);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ADDR'($urandom_range(0, 63)), {8{$urandom()}},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ADDR'($urandom_range(0, 63)), {8{$urandom()}});
        drain();
    endtask

    task automatic test_clear();
        int n;
        for (int i = 0; i < 10; i++)
            drive(1'b1, 1'b1, ADDR'($urandom_range(0, DEPTH - 1)), {8{$urandom()}},
                  1'b0, 1'b0, '0, '0);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        count_busy(1'b1, 1'b1, n);
        check_busy_len("clr_req_clear_len", n);
        n_vec++;
        if ({err_oor, err_col} !== 2'b11) begin
            n_err++;
            $display("FAIL sticky_after_clear: got err_oor=%b err_col=%b required 1 1", err_oor, err_col);
        end
        model_zero();
        read_all_zero();
    endtask

    task automatic test_reset_mid_clear();
        int n;
        drive(1'b1, 1'b1, 6'd40, 256'h55, 1'b0, 1'b0, '0, '0);
        drain();
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_vec++;
        if ({err_oor, err_col, a_vld, b_vld} !== 4'b0 || a_data_out !== '0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_clear: got err=%b%b vld=%b%b busy=%b, required 0000 busy 1",
                     err_oor, err_col, a_vld, b_vld, busy);
        end
        count_busy(1'b0, 1'b0, n);
        check_busy_len("reset_restart_len", n);
        model_zero();
        read_all_zero();
    endtask

    initial begin
        model_zero();
        test_reset();
        test_cross_port();
        test_collision();
        test_oor();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
